// File: rtl/csr_pkg.sv
// Shared types and sizing helpers for the CSR weight encoder.
// Default kernel geometry is captured here for reference by users of the block.
package csr_pkg;

    typedef enum logic {
        SCAN,
        HOLD
    } state_t;

    localparam int KER_SIZE_D    = 3;
    localparam int IN_CHANNELS_D = 1;
    localparam int KPOS          = KER_SIZE_D * KER_SIZE_D * IN_CHANNELS_D;
    localparam int ROWS          = KER_SIZE_D * IN_CHANNELS_D;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/csr_weight_encoder_nz_detect.sv
// Flags a kernel position as non-zero when any filter carries a non-zero value.
// Purely combinational OR-reduce across all filter lanes.
module nz_detect #(
    parameter int FILTERS  = 2,
    parameter int BIT_SIZE = 16
) (
    input  logic [FILTERS*BIT_SIZE-1:0] in_weights,
    output logic                        nz
);

    always_comb begin
        nz = 1'b0;
        for (int f = 0; f < FILTERS; f++) begin
            nz = nz | (|in_weights[f*BIT_SIZE +: BIT_SIZE]);
        end
    end

endmodule

// File: rtl/csr_weight_encoder.sv
// Dense-to-CSR kernel encoder feeding vector_generator.
// Optional CSR_ENC_OVERFLOW_CHECK_EN: saturate fields and flag overflow on out_err.
module csr_weight_encoder
    import csr_pkg::*;
#(
    parameter int IN_CHANNELS        = 1,
    parameter int KER_SIZE           = 3,
    parameter int FILTERS            = 2,
    parameter int NON_ZERO_WEIGHTS   = 6,
    parameter int BIT_SIZE           = 16,
    parameter int INDEX_BIT_SIZE     = 3,
    parameter int R_POINTER_BIT_SIZE = 3
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [FILTERS*BIT_SIZE-1:0]                      in_weights,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [FILTERS*NON_ZERO_WEIGHTS*BIT_SIZE-1:0]     out_weights,
    output logic [NON_ZERO_WEIGHTS*INDEX_BIT_SIZE-1:0]       out_index,
    output logic [KER_SIZE*IN_CHANNELS*R_POINTER_BIT_SIZE-1:0] out_r_pointer,
    output logic                                             out_err
);

    localparam int N_ROWS = KER_SIZE * IN_CHANNELS;
    localparam int NZW    = NON_ZERO_WEIGHTS;
    localparam int SW     = cnt_w(NZW);
    localparam int GW     = cnt_w(KER_SIZE);
    localparam int CLW    = cnt_w(KER_SIZE - 1);
    localparam int RW     = cnt_w(N_ROWS - 1);

    state_t state_q, state_d;

    logic                          nz, accept, hs, store;
    logic                          last_col, last_row;
    logic [SW-1:0]                 slot_q;
    logic [GW-1:0]                 gap_q, gap_d, cnt_q, cnt_d;
    logic [CLW-1:0]                col_q;
    logic [RW-1:0]                 row_q;
    logic [INDEX_BIT_SIZE-1:0]     idx_val;
    logic [R_POINTER_BIT_SIZE-1:0] rp_val;

    logic [BIT_SIZE-1:0]           wt_q [FILTERS][NZW];
    logic [INDEX_BIT_SIZE-1:0]     idx_q [NZW];
    logic [R_POINTER_BIT_SIZE-1:0] rp_q  [N_ROWS];

    nz_detect #(
        .FILTERS  (FILTERS),
        .BIT_SIZE (BIT_SIZE)
    ) u_nz (
        .in_weights (in_weights),
        .nz         (nz)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= SCAN;
        else      state_q <= state_d;
    end

    // in_ready is gated by rst so it stays low while reset is held
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            SCAN: begin
                in_ready = rst;
                if (in_valid && rst && last_col && last_row) state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_d = SCAN;
            end
            default: state_d = SCAN;
        endcase
    end

    assign accept = in_valid & in_ready;
    assign hs     = out_valid & out_ready;

`ifdef CSR_ENC_OVERFLOW_CHECK_EN
    localparam logic [31:0] IDX_MAX = 32'((1 << INDEX_BIT_SIZE) - 1);
    localparam logic [31:0] RP_MAX  = 32'((1 << R_POINTER_BIT_SIZE) - 1);
    logic ovf, err_q;
`endif

    always_comb begin
        store    = nz && (slot_q < SW'(NZW));
        last_col = (col_q == CLW'(KER_SIZE - 1));
        last_row = (row_q == RW'(N_ROWS - 1));
        cnt_d    = cnt_q + GW'(store);
        gap_d    = nz ? '0 : gap_q + GW'(1);
`ifdef CSR_ENC_OVERFLOW_CHECK_EN
        idx_val  = (32'(gap_q) > IDX_MAX) ? INDEX_BIT_SIZE'(IDX_MAX)
                                          : INDEX_BIT_SIZE'(gap_q);
        rp_val   = (32'(cnt_d) > RP_MAX) ? R_POINTER_BIT_SIZE'(RP_MAX)
                                         : R_POINTER_BIT_SIZE'(cnt_d);
        ovf      = (nz && !store)
                || (store && (32'(gap_q) > IDX_MAX))
                || (last_col && (32'(cnt_d) > RP_MAX));
`else
        idx_val  = INDEX_BIT_SIZE'(gap_q);
        rp_val   = R_POINTER_BIT_SIZE'(cnt_d);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q <= '0;
            gap_q  <= '0;
            cnt_q  <= '0;
            col_q  <= '0;
            row_q  <= '0;
            for (int s = 0; s < NZW; s++) begin
                idx_q[s] <= '0;
                for (int f = 0; f < FILTERS; f++) wt_q[f][s] <= '0;
            end
            for (int r = 0; r < N_ROWS; r++) rp_q[r] <= '0;
        end else if (hs) begin
            slot_q <= '0;
            gap_q  <= '0;
            cnt_q  <= '0;
            col_q  <= '0;
            row_q  <= '0;
            for (int s = 0; s < NZW; s++) begin
                idx_q[s] <= '0;
                for (int f = 0; f < FILTERS; f++) wt_q[f][s] <= '0;
            end
            for (int r = 0; r < N_ROWS; r++) rp_q[r] <= '0;
        end else if (accept) begin
            if (store) begin
                idx_q[slot_q] <= idx_val;
                for (int f = 0; f < FILTERS; f++) begin
                    wt_q[f][slot_q] <= in_weights[(FILTERS-1-f)*BIT_SIZE +: BIT_SIZE];
                end
            end
            slot_q <= (last_col && last_row) ? '0 : slot_q + SW'(store);
            if (last_col) begin
                rp_q[row_q] <= rp_val;
                cnt_q       <= '0;
                gap_q       <= '0;
                col_q       <= '0;
                row_q       <= last_row ? '0 : row_q + RW'(1);
            end else begin
                cnt_q <= cnt_d;
                gap_q <= gap_d;
                col_q <= col_q + CLW'(1);
            end
        end
    end

`ifdef CSR_ENC_OVERFLOW_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                err_q <= 1'b0;
        else if (hs)             err_q <= 1'b0;
        else if (accept && ovf)  err_q <= 1'b1;
    end
    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    always_comb begin
        out_weights   = '0;
        out_index     = '0;
        out_r_pointer = '0;
        for (int f = 0; f < FILTERS; f++) begin
            for (int s = 0; s < NZW; s++) begin
                out_weights[(FILTERS*NZW-1-f*NZW-s)*BIT_SIZE +: BIT_SIZE] = wt_q[f][s];
            end
        end
        for (int s = 0; s < NZW; s++) begin
            out_index[(NZW-1-s)*INDEX_BIT_SIZE +: INDEX_BIT_SIZE] = idx_q[s];
        end
        for (int r = 0; r < N_ROWS; r++) begin
            out_r_pointer[(N_ROWS-1-r)*R_POINTER_BIT_SIZE +: R_POINTER_BIT_SIZE] = rp_q[r];
        end
    end

endmodule

// File: tb/tb_csr_weight_encoder.sv
// Directed and randomized checks of csr_weight_encoder against a positional CSR model.
// Two instances: single-channel default and a two-channel back-to-back stream.
module tb_csr_weight_encoder;

    localparam int NZW = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic         in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b0, out_err_a;
    logic [31:0]  in_w_a = '0;
    logic [191:0] out_w_a;
    logic [17:0]  out_idx_a;
    logic [8:0]   out_rp_a;

    logic         in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b0, out_err_b;
    logic [31:0]  in_w_b = '0;
    logic [191:0] out_w_b;
    logic [17:0]  out_idx_b;
    logic [17:0]  out_rp_b;

    csr_weight_encoder #(.IN_CHANNELS(1)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_weights(in_w_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_weights(out_w_a), .out_index(out_idx_a),
        .out_r_pointer(out_rp_a), .out_err(out_err_a)
    );

    csr_weight_encoder #(.IN_CHANNELS(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_weights(in_w_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_weights(out_w_b), .out_index(out_idx_b),
        .out_r_pointer(out_rp_b), .out_err(out_err_b)
    );

    int checks = 0;
    int errors = 0;

    int kf0[$];
    int kf1[$];

    logic [191:0] exp_w;
    logic [17:0]  exp_idx;
    logic [31:0]  exp_rp;
    logic         exp_err;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] fld(input int v);
`ifdef CSR_ENC_OVERFLOW_CHECK_EN
        return (v > 7) ? 3'd7 : 3'(v);
`else
        return 3'(v);
`endif
    endfunction

    // CSR built straight from kernel positions: stored non-zeros are the first NZW
    task automatic model(input int k, input int c);
        int rows, ns, nnz, r, col, g;
        bit ovf;
        int rc[];
        int lc[];
        rows = k * c;
        rc = new[rows];
        lc = new[rows];
        foreach (rc[i]) begin rc[i] = 0; lc[i] = -1; end
        exp_w = '0; exp_idx = '0; exp_rp = '0;
        ns = 0; nnz = 0; ovf = 1'b0;
        for (int p = 0; p < k * k * c; p++) begin
            if (kf0[p] != 0 || kf1[p] != 0) begin
                nnz++;
                if (ns < NZW) begin
                    r = p / k;
                    col = p % k;
                    g = col - lc[r] - 1;
                    lc[r] = col;
                    rc[r]++;
                    if (g > 7) ovf = 1'b1;
                    exp_w[(2*NZW-1-ns)*16 +: 16] = 16'(kf0[p]);
                    exp_w[(NZW-1-ns)*16 +: 16]   = 16'(kf1[p]);
                    exp_idx[(NZW-1-ns)*3 +: 3]   = fld(g);
                    ns++;
                end
            end
        end
        for (int i = 0; i < rows; i++) begin
            if (rc[i] > 7) ovf = 1'b1;
            exp_rp[(rows-1-i)*3 +: 3] = fld(rc[i]);
        end
        if (nnz > NZW) ovf = 1'b1;
`ifdef CSR_ENC_OVERFLOW_CHECK_EN
        exp_err = ovf;
`else
        exp_err = 1'b0;
`endif
    endtask

    task automatic rand_kernel(input int n, input int dens);
        kf0.delete();
        kf1.delete();
        for (int i = 0; i < n; i++) begin
            kf0.push_back(($urandom_range(99) < dens) ? int'($urandom_range(65535)) : 0);
            kf1.push_back(($urandom_range(99) < dens) ? int'($urandom_range(65535)) : 0);
        end
    endtask

    task automatic run_a(input int nbeats, input bit gaps);
        chk("a_in_ready_pre", in_ready_a, 1'b1);
        for (int p = 0; p < nbeats; p++) begin
            if (gaps && $urandom_range(3) == 0) begin
                in_valid_a = 1'b0;
                @(posedge clk); #1;
            end
            in_valid_a = 1'b1;
            in_w_a = {16'(kf0[p]), 16'(kf1[p])};
            @(posedge clk); #1;
        end
        in_valid_a = 1'b0;
    endtask

    task automatic check_a(input string tag);
        model(3, 1);
        chk({tag, "_valid"}, out_valid_a, 1'b1);
        chk({tag, "_weights"}, out_w_a, exp_w);
        chk({tag, "_index"}, out_idx_a, exp_idx);
        chk({tag, "_rptr"}, out_rp_a, exp_rp);
        chk({tag, "_err"}, out_err_a, exp_err);
    endtask

    task automatic hs_a(input string tag);
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        out_ready_a = 1'b0;
        in_valid_a = 1'b0;
        chk({tag, "_hs_valid"}, out_valid_a, 1'b0);
        chk({tag, "_hs_ready"}, in_ready_a, 1'b1);
    endtask

    initial begin
        logic [191:0] snap_w;
        logic [17:0]  snap_idx;
        logic [8:0]   snap_rp;
        int prev;

        // reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready_a, 1'b0);
        chk("rst_out_valid", out_valid_a, 1'b0);
        chk("rst_weights", out_w_a, '0);
        chk("rst_index", out_idx_a, '0);
        chk("rst_rptr", out_rp_a, '0);
        chk("rst_err", out_err_a, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", in_ready_a, 1'b1);

        // basic pattern
        kf0 = '{1, 0, 2, 0, 3, 0, 4, 0, 5};
        kf1 = '{7, 0, 0, 0, 0, 0, 0, 0, 8};
        run_a(9, 1'b0);
        check_a("basic");
        chk("basic_rptr_c", out_rp_a, 9'h08A);
        chk("basic_index_c", out_idx_a, 18'h01208);
        chk("basic_w_c", out_w_a,
            192'h0001_0002_0003_0004_0005_0000_0007_0000_0000_0000_0008_0000);
        hs_a("basic");
        chk("basic_cleared", out_w_a, '0);

        // all-zero
        kf0 = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        kf1 = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_a(9, 1'b1);
        check_a("zero");
        chk("zero_rptr_c", out_rp_a, '0);
        hs_a("zero");

        // fully dense
        kf0 = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        kf1 = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        run_a(9, 1'b0);
        check_a("dense");
        chk("dense_rptr_c", out_rp_a, 9'h0D8);
        chk("dense_index_c", out_idx_a, '0);
`ifdef CSR_ENC_OVERFLOW_CHECK_EN
        chk("dense_err_c", out_err_a, 1'b1);
`else
        chk("dense_err_c", out_err_a, 1'b0);
`endif
        hs_a("dense");
        chk("dense_err_clr", out_err_a, 1'b0);

        // backpressure
        rand_kernel(9, 50);
        run_a(9, 1'b0);
        check_a("bp");
        snap_w = out_w_a;
        snap_idx = out_idx_a;
        snap_rp = out_rp_a;
        for (int i = 0; i < 5; i++) begin
            in_valid_a = 1'b1;
            in_w_a = $urandom;
            @(posedge clk); #1;
            chk("bp_valid", out_valid_a, 1'b1);
            chk("bp_ready", in_ready_a, 1'b0);
            chk("bp_w_stable", out_w_a, snap_w);
            chk("bp_idx_stable", out_idx_a, snap_idx);
            chk("bp_rp_stable", out_rp_a, snap_rp);
        end
        hs_a("bp");
        chk("bp_cleared", out_rp_a, '0);

        // random kernels with idle gaps
        for (int n = 0; n < 6; n++) begin
            rand_kernel(9, 30 + 10 * n);
            run_a(9, 1'b1);
            check_a("rand");
            hs_a("rand");
        end

        // reset mid-kernel
        kf0 = '{1, 0, 2, 0, 3, 0, 4, 0, 5};
        kf1 = '{7, 0, 0, 0, 0, 0, 0, 0, 8};
        run_a(4, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid_a, 1'b0);
        chk("mid_rst_ready", in_ready_a, 1'b0);
        chk("mid_rst_w", out_w_a, '0);
        chk("mid_rst_idx", out_idx_a, '0);
        chk("mid_rst_rp", out_rp_a, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_a(9, 1'b0);
        check_a("post_rst");
        chk("post_rst_rptr_c", out_rp_a, 9'h08A);
        chk("post_rst_index_c", out_idx_a, 18'h01208);
        hs_a("post_rst");

        // back-to-back, two channels
        out_ready_b = 1'b1;
        prev = 0;
        rand_kernel(18, 40);
        chk("b2b_ready_pre", in_ready_b, 1'b1);
        for (int n = 0; n < 4; n++) begin
            for (int p = 0; p < 18; p++) begin
                in_valid_b = 1'b1;
                in_w_b = {16'(kf0[p]), 16'(kf1[p])};
                @(posedge clk); #1;
            end
            model(3, 2);
            chk("b2b_valid", out_valid_b, 1'b1);
            chk("b2b_ready_low", in_ready_b, 1'b0);
            chk("b2b_weights", out_w_b, exp_w);
            chk("b2b_index", out_idx_b, exp_idx);
            chk("b2b_rptr", out_rp_b, exp_rp);
            chk("b2b_err", out_err_b, exp_err);
            if (n > 0) chk("b2b_period", cyc - prev, 19);
            prev = cyc;
            rand_kernel(18, 40);
            in_w_b = {16'(kf0[0]), 16'(kf1[0])};
            @(posedge clk); #1;
            chk("b2b_hs_valid", out_valid_b, 1'b0);
            chk("b2b_hs_ready", in_ready_b, 1'b1);
        end
        in_valid_b = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
